soi_trace_monitor: RTL
======================

// Module: soi_trace_monitor
// PURPOSE
// - Observation counterpart of the fault-injection path: samples a vector of signals-of-interest (SOI) every clock.
// - On each SOI change, emits a timestamped record into a buffer that the host/DPI side drains via valid/ready.
// - Sits beside the DUT in fiapp benches.
// - Injection writes into RTL; this block reads RTL state back out cycle-accurately.
// PARAMETERS
// - SOI_WIDTH  3   number of observed signals
// - TS_WIDTH   16  free-running timestamp width (wraps)
// - DEPTH      8   record FIFO entries, power of two, >=2
// - DROP_W     8   drop counter width (saturating)
// PORTS
// - clk          in   1          single clock, all logic posedge
// - reset        in   1          synchronous, active-high
// - enable       in   1          capture enable
// - soi          in   SOI_WIDTH  observed signals (e.g. {o3,o2,o1})
// - rec_valid    out  1          head record available
// - rec_ready    in   1          consumer accepts head; pop when rec_valid&&rec_ready
// - rec_soi      out  SOI_WIDTH  head record SOI value
// - rec_ts       out  TS_WIDTH   head record timestamp
// - rec_ovf      out  1          one or more records dropped immediately before this one
// - fifo_level   out  $clog2(DEPTH)+1  current occupancy
// - drop_count   out  DROP_W     total dropped records, saturates at all-ones
// BEHAVIOUR
// - Reset (sync, active-high): ts=0, FIFO empty, rec_valid=0, rec_soi=0, rec_ts=0, rec_ovf=0,
//   fifo_level=0, drop_count=0, ovf_pending=0, prev_soi=0, armed=0.
// - Reset asserted mid-operation discards all buffered records on that edge; nothing is flushed out.
// - ts increments every cycle out of reset regardless of enable; wraps 2^TS_WIDTH-1 -> 0 silently.
// - Capture event (combinational, cycle N): enable && (!armed || soi != prev_soi).
//   - Event with !armed is the baseline record.
// - armed: set on any enabled cycle; cleared when enable=0, so re-enable always emits a new baseline.
// - prev_soi <= soi on every enabled cycle; held when enable=0.
// - Record = {ovf_pending, ts(cycle N), soi(cycle N)}; written at edge ending cycle N.
//   - Head visible (rec_valid=1) in cycle N+1: one-cycle latency when the FIFO was empty.
// - Push accepted iff level<DEPTH, or a pop occurs in the same cycle (full+pop+push -> level stays DEPTH).
// - Push rejected (full, no pop):
//   - record lost; drop_count+1 (saturating); ovf_pending<=1.
// - Accepted push clears ovf_pending; that record carries rec_ovf=1.
// - Push+pop on empty FIFO: no pop (rec_valid=0); push lands; level becomes 1.
// - rec_* held stable while rec_valid && !rec_ready.
// - rec_* outputs driven from the head register array entry (combinational read); 0 when empty.
// - fifo_level = registered count; +1 push only, -1 pop only, unchanged on push+pop.
// - Pointers wrap modulo DEPTH.
// STRUCTURE
// - soi_trace_pkg:
//   - typedef struct packed {logic ovf; logic [TS_WIDTH-1:0] ts; logic [SOI_WIDTH-1:0] soi;} soi_rec_t
//   - default width localparams.
// - Sub-module soi_trace_fifo: synchronous FIFO of soi_rec_t (push/pop/full/empty/level, first-word-fall-through).
// - Top: ts counter, prev_soi/armed, event detect, drop/ovf logic.
// TESTING
// - Baseline:
//   - Stimulus: reset 2 cycles, enable=1 at ts=5, soi=3'b010 constant, rec_ready=1.
//   - Response: exactly one record {ovf=0, ts=5, soi=010}.
// - Change detect:
//   - Stimulus: soi toggles 010->011 at ts=9, 011->100 at ts=12.
//   - Response: records ts=9/011 then ts=12/100; none for unchanged cycles.
// - Overflow:
//   - Stimulus: DEPTH=8, rec_ready=0, soi changes every cycle for 11 events.
//   - Response: level=8, drop_count=3.
//   - Then rec_ready=1 and one more change: 9th record has rec_ovf=1.
// - Full + simultaneous push/pop:
//   - Stimulus: level=8, rec_ready=1 and change in same cycle.
//   - Response: level stays 8, drop_count unchanged.
// - Reset mid-operation:
//   - Stimulus: level=5, assert reset 1 cycle.
//   - Response: next cycle rec_valid=0, level=0, drop_count=0, ts=0.
// - Enable gap / ts wrap:
//   - Stimulus: TS_WIDTH=4, enable drops at ts=14, reasserts at ts=1 with soi unchanged.
//   - Response: new baseline record ts=1.

Source files
------------

// File: rtl/soi_trace_pkg.sv
// Shared types and default widths for the SOI trace monitor.
package soi_trace_pkg;

  localparam int unsigned SOI_WIDTH_DEF = 3;
  localparam int unsigned TS_WIDTH_DEF  = 16;
  localparam int unsigned DEPTH_DEF     = 8;
  localparam int unsigned DROP_W_DEF    = 8;

  // One trace record: overflow marker, capture timestamp, sampled SOI value.
  typedef struct packed {
    logic                    ovf;
    logic [TS_WIDTH_DEF-1:0] ts;
    logic [SOI_WIDTH_DEF-1:0] soi;
  } soi_rec_t;

endpackage

// File: rtl/soi_trace_fifo.sv
// First-word-fall-through record FIFO; caller guarantees push/pop are legal.
module soi_trace_fifo
  import soi_trace_pkg::*;
#(
  parameter type         rec_t = soi_rec_t,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  rec_t                   wdata,
  output rec_t                   rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  rec_t          mem_q [DEPTH];
  rec_t          mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards everything buffered.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == LW'(DEPTH));
  assign level = count_q;
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/soi_trace_monitor.sv
// Samples SOI every clock and queues a timestamped record on each change.
module soi_trace_monitor
  import soi_trace_pkg::*;
#(
  parameter int unsigned SOI_WIDTH = SOI_WIDTH_DEF,
  parameter int unsigned TS_WIDTH  = TS_WIDTH_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned DROP_W    = DROP_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [SOI_WIDTH-1:0]   soi,
  output logic                   rec_valid,
  input  logic                   rec_ready,
  output logic [SOI_WIDTH-1:0]   rec_soi,
  output logic [TS_WIDTH-1:0]    rec_ts,
  output logic                   rec_ovf,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [DROP_W-1:0]      drop_count
);

  typedef struct packed {
    logic                 ovf;
    logic [TS_WIDTH-1:0]  ts;
    logic [SOI_WIDTH-1:0] soi;
  } rec_t;

  logic [TS_WIDTH-1:0]  ts_q, ts_d;
  logic [SOI_WIDTH-1:0] prev_soi_q, prev_soi_d;
  logic                 armed_q, armed_d;
  logic                 ovf_pending_q, ovf_pending_d;
  logic [DROP_W-1:0]    drop_q, drop_d;

  logic event_c, pop_c, push_c;
  logic fifo_full, fifo_empty;
  rec_t wrec_c, head_rec;

  // Event detection, push/pop qualification and drop bookkeeping.
  always_comb begin
    ts_d          = ts_q + TS_WIDTH'(1);
    armed_d       = enable;
    prev_soi_d    = prev_soi_q;
    ovf_pending_d = ovf_pending_q;
    drop_d        = drop_q;
    if (enable) begin
      prev_soi_d = soi;
    end
    event_c    = enable && (!armed_q || (soi != prev_soi_q));
    pop_c      = !fifo_empty && rec_ready;
    push_c     = event_c && (!fifo_full || pop_c);
    wrec_c.ovf = ovf_pending_q;
    wrec_c.ts  = ts_q;
    wrec_c.soi = soi;
    if (push_c) begin
      ovf_pending_d = 1'b0;
    end else if (event_c) begin
      ovf_pending_d = 1'b1;
      if (drop_q != '1) begin
        drop_d = drop_q + DROP_W'(1);
      end
    end
  end

  // Timestamp, change-tracking and drop state.
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q          <= '0;
      prev_soi_q    <= '0;
      armed_q       <= 1'b0;
      ovf_pending_q <= 1'b0;
      drop_q        <= '0;
    end else begin
      ts_q          <= ts_d;
      prev_soi_q    <= prev_soi_d;
      armed_q       <= armed_d;
      ovf_pending_q <= ovf_pending_d;
      drop_q        <= drop_d;
    end
  end

  soi_trace_fifo #(
    .rec_t (rec_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_c),
    .pop   (pop_c),
    .wdata (wrec_c),
    .rdata (head_rec),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign rec_valid  = !fifo_empty;
  assign rec_soi    = head_rec.soi;
  assign rec_ts     = head_rec.ts;
  assign rec_ovf    = head_rec.ovf;
  assign drop_count = drop_q;

endmodule
